// File: rtl/rcu_rst_seq.sv
// Staged reset sequencer fed by the RCU register block: holds all domain resets after any
// request, releases them one by one, and keeps a sticky record of what caused the reset.
module rcu_rst_seq #(
    parameter int DOMAIN_NUM  = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ext_rst_req_i,
    input  logic                  wdg_rst_req_i,
    input  logic                  sw_rst_req_i,
    input  logic [DOMAIN_NUM-1:0] dom_sw_rst_i,
    input  logic                  stat_clr_i,
    output logic [DOMAIN_NUM-1:0] dom_rst_o,
    output logic                  busy_o,
    output logic [3:0]            cause_o
);

    localparam int HOLD_W = $clog2(HOLD_CYC);
    localparam int STAG_W = $clog2(STAGGER_CYC + 1);
    localparam int IDX_W  = $clog2(DOMAIN_NUM + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DOMAIN_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [HOLD_W-1:0]       hold_reg, hold_next;
    logic [STAG_W-1:0]       stag_reg, stag_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    ext_meta_reg, ext_sync_reg;
    logic [DOMAIN_NUM-1:0]   dom_rst_reg;
    logic [DOMAIN_NUM-1:0]   seq_rst_next;
    logic [3:0]              cause_reg, cause_next;
    logic                    greq;

    // The external pin is asynchronous; only its synchronized level is ever used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_meta_reg <= 1'b0;
            ext_sync_reg <= 1'b0;
        end else begin
            ext_meta_reg <= ext_rst_req_i;
            ext_sync_reg <= ext_meta_reg;
        end
    end

    assign greq = ext_sync_reg | wdg_rst_req_i | sw_rst_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_ASSERT;
            hold_reg  <= '0;
            stag_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            stag_reg  <= stag_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        stag_next  = stag_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (greq) begin
                    state_next = ST_ASSERT;
                    hold_next  = '0;
                    stag_next  = '0;
                    idx_next   = '0;
                end
            end
            ST_ASSERT: begin
                if (greq) begin
                    hold_next = '0;
                end else if (hold_reg == HOLD_LAST) begin
                    // Domain 0 drops on this edge, so one domain counts as released.
                    state_next = (DOMAIN_NUM == 1) ? ST_IDLE : ST_RELEASE;
                    stag_next  = '0;
                    idx_next   = IDX_W'(1);
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (greq) begin
                    state_next = ST_ASSERT;
                    hold_next  = '0;
                    stag_next  = '0;
                    idx_next   = '0;
                end else if (stag_reg == STAG_LAST) begin
                    stag_next = '0;
                    idx_next  = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    stag_next = stag_reg + STAG_W'(1);
                end
            end
            default: begin
                state_next = ST_ASSERT;
                hold_next  = '0;
                stag_next  = '0;
                idx_next   = '0;
            end
        endcase
    end

    // idx counts released domains; domain k stays in reset while k >= idx.
    generate
        for (genvar gi = 0; gi < DOMAIN_NUM; gi++) begin : g_mask
            assign seq_rst_next[gi] = (state_next == ST_ASSERT) ||
                                      ((state_next == ST_RELEASE) && (idx_next <= IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dom_rst_reg <= '1;
        end else begin
            dom_rst_reg <= seq_rst_next | dom_sw_rst_i;
        end
    end

    // A new cause beats a same-cycle clear for its own bit only.
    assign cause_next = {sw_rst_req_i, wdg_rst_req_i, ext_sync_reg, 1'b0} |
                        (cause_reg & {4{~stat_clr_i}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_reg <= 4'b0001;
        end else begin
            cause_reg <= cause_next;
        end
    end

    assign dom_rst_o = dom_rst_reg;
    assign busy_o    = (state_reg != ST_IDLE);
    assign cause_o   = cause_reg;

endmodule

// File: tb/tb_rcu_rst_seq.sv
// Directed bench: stimulus queues edge-stamped expectations, a negedge monitor pops and checks them.
module tb_rcu_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       ext_rst_req_i = 1'b0;
    logic       wdg_rst_req_i = 1'b0;
    logic       sw_rst_req_i = 1'b0;
    logic [3:0] dom_sw_rst_i = 4'b0000;
    logic       stat_clr_i = 1'b0;
    logic [3:0] dom_rst_o;
    logic       busy_o;
    logic [3:0] cause_o;

    rcu_rst_seq #(
        .DOMAIN_NUM (4),
        .HOLD_CYC   (16),
        .STAGGER_CYC(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ext_rst_req_i(ext_rst_req_i),
        .wdg_rst_req_i(wdg_rst_req_i),
        .sw_rst_req_i (sw_rst_req_i),
        .dom_sw_rst_i (dom_sw_rst_i),
        .stat_clr_i   (stat_clr_i),
        .dom_rst_o    (dom_rst_o),
        .busy_o       (busy_o),
        .cause_o      (cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         at_edge;
        string      name;
        logic [3:0] dom;
        logic       busy;
        logic [3:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic expect_at(input int e, input string name, input logic [3:0] dom,
                             input logic busy, input logic [3:0] cause);
        exp_t x;
        x.at_edge = e;
        x.name    = name;
        x.dom     = dom;
        x.busy    = busy;
        x.cause   = cause;
        exp_q.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Monitor: DUT outputs are valid every cycle; compare whenever an expectation is due.
    always @(negedge clk_i) begin
        while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
            exp_t x;
            x = exp_q.pop_front();
            if (x.at_edge < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL %s: missed at edge %0d, now edge %0d", x.name, x.at_edge, edge_cnt);
            end else begin
                checks += 3;
                if (dom_rst_o !== x.dom) begin
                    errors++;
                    $display("FAIL %s dom_rst_o @%0d: got %b want %b", x.name, edge_cnt, dom_rst_o, x.dom);
                end
                if (busy_o !== x.busy) begin
                    errors++;
                    $display("FAIL %s busy_o @%0d: got %b want %b", x.name, edge_cnt, busy_o, x.busy);
                end
                if (cause_o !== x.cause) begin
                    errors++;
                    $display("FAIL %s cause_o @%0d: got %b want %b", x.name, edge_cnt, cause_o, x.cause);
                end
                $display("check %-10s edge %0d dom=%b busy=%b cause=%b", x.name, edge_cnt,
                         dom_rst_o, busy_o, cause_o);
            end
        end
    end

    initial begin
        int e0, p, r, d1, w, s, c, a, t;

        // POR: three reset edges, then the 16/4 staged release.
        for (int i = 1; i <= 3; i++) expect_at(i, "por_hold", 4'b1111, 1'b1, 4'b0001);
        wait_edge(3);
        rst_i = 1'b0;
        e0 = edge_cnt;
        expect_at(e0 + 15, "por_15", 4'b1111, 1'b1, 4'b0001);
        expect_at(e0 + 16, "por_d0", 4'b1110, 1'b1, 4'b0001);
        expect_at(e0 + 19, "por_19", 4'b1110, 1'b1, 4'b0001);
        expect_at(e0 + 20, "por_d1", 4'b1100, 1'b1, 4'b0001);
        expect_at(e0 + 24, "por_d2", 4'b1000, 1'b1, 4'b0001);
        expect_at(e0 + 27, "por_27", 4'b1000, 1'b1, 4'b0001);
        expect_at(e0 + 28, "por_d3", 4'b0000, 1'b0, 4'b0001);
        wait_edge(e0 + 30);

        // Software pulse in IDLE.
        p = edge_cnt + 1;
        expect_at(p,      "sw_asrt", 4'b1111, 1'b1, 4'b1001);
        expect_at(p + 15, "sw_15",   4'b1111, 1'b1, 4'b1001);
        expect_at(p + 16, "sw_d0",   4'b1110, 1'b1, 4'b1001);
        expect_at(p + 20, "sw_d1",   4'b1100, 1'b1, 4'b1001);
        expect_at(p + 24, "sw_d2",   4'b1000, 1'b1, 4'b1001);
        expect_at(p + 28, "sw_d3",   4'b0000, 1'b0, 4'b1001);
        sw_rst_req_i = 1'b1;
        wait_edge(p);
        sw_rst_req_i = 1'b0;
        wait_edge(p + 30);

        // External request held for 10 cycles, then a watchdog abort during RELEASE.
        r  = edge_cnt;
        d1 = r + 32;
        w  = d1 + 2;
        expect_at(r + 2,  "ext_sync",  4'b0000, 1'b0, 4'b1001);
        expect_at(r + 3,  "ext_asrt",  4'b1111, 1'b1, 4'b1011);
        expect_at(r + 27, "ext_27",    4'b1111, 1'b1, 4'b1011);
        expect_at(r + 28, "ext_d0",    4'b1110, 1'b1, 4'b1011);
        expect_at(d1,     "ext_d1",    4'b1100, 1'b1, 4'b1011);
        expect_at(d1 + 1, "pre_wdg",   4'b1100, 1'b1, 4'b1011);
        expect_at(w,      "wdg_abort", 4'b1111, 1'b1, 4'b1111);
        expect_at(w + 15, "wdg_15",    4'b1111, 1'b1, 4'b1111);
        expect_at(w + 16, "wdg_d0",    4'b1110, 1'b1, 4'b1111);
        expect_at(w + 20, "wdg_d1",    4'b1100, 1'b1, 4'b1111);
        expect_at(w + 24, "wdg_d2",    4'b1000, 1'b1, 4'b1111);
        expect_at(w + 28, "wdg_d3",    4'b0000, 1'b0, 4'b1111);
        ext_rst_req_i = 1'b1;
        wait_edge(r + 10);
        ext_rst_req_i = 1'b0;
        wait_edge(d1 + 1);
        wdg_rst_req_i = 1'b1;
        wait_edge(w);
        wdg_rst_req_i = 1'b0;
        wait_edge(w + 30);

        // Per-domain soft reset in IDLE.
        s = edge_cnt;
        expect_at(s,     "dsw_pre",  4'b0000, 1'b0, 4'b1111);
        expect_at(s + 1, "dsw_on",   4'b0100, 1'b0, 4'b1111);
        expect_at(s + 5, "dsw_hold", 4'b0100, 1'b0, 4'b1111);
        expect_at(s + 6, "dsw_off",  4'b0000, 1'b0, 4'b1111);
        dom_sw_rst_i = 4'b0100;
        wait_edge(s + 5);
        dom_sw_rst_i = 4'b0000;
        wait_edge(s + 8);

        // Plain status clear.
        c = edge_cnt + 1;
        expect_at(c, "clr_only", 4'b0000, 1'b0, 4'b0000);
        stat_clr_i = 1'b1;
        wait_edge(c);
        stat_clr_i = 1'b0;
        wait_edge(c + 2);

        // Re-POR plus a short ext pulse to build cause 4'b0011.
        a = edge_cnt;
        expect_at(a + 1,  "rpor",     4'b1111, 1'b1, 4'b0001);
        expect_at(a + 4,  "rpor_ext", 4'b1111, 1'b1, 4'b0011);
        expect_at(a + 20, "rpor_20",  4'b1111, 1'b1, 4'b0011);
        expect_at(a + 21, "rpor_d0",  4'b1110, 1'b1, 4'b0011);
        expect_at(a + 33, "rpor_d3",  4'b0000, 1'b0, 4'b0011);
        rst_i = 1'b1;
        wait_edge(a + 1);
        rst_i = 1'b0;
        ext_rst_req_i = 1'b1;
        wait_edge(a + 3);
        ext_rst_req_i = 1'b0;
        wait_edge(a + 35);

        // Clear and software request in the same cycle: set wins for bit 3 only.
        t = edge_cnt;
        expect_at(t + 1,  "clr_sw",    4'b1111, 1'b1, 4'b1000);
        expect_at(t + 17, "clr_sw_d0", 4'b1110, 1'b1, 4'b1000);
        expect_at(t + 29, "clr_sw_d3", 4'b0000, 1'b0, 4'b1000);
        stat_clr_i   = 1'b1;
        sw_rst_req_i = 1'b1;
        wait_edge(t + 1);
        stat_clr_i   = 1'b0;
        sw_rst_req_i = 1'b0;
        wait_edge(t + 32);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: edge %0d, want completion", edge_cnt);
        $fatal(1, "timeout");
    end

endmodule
